msg_sequencer: RTL
==================

MSG_SEQUENCER -- requirements
Module: msg_sequencer

Interface
REQ-001 Parameter DEPTH, default 20, maximum message length in characters (2..64).
REQ-002 Parameter CHAR_W, default 7, character width in bits (ASCII).
REQ-003 Parameter AW, default 5, address width; SHALL satisfy 2**AW >= DEPTH.
REQ-004 Clock and reset are fixed: one clock; reset is asynchronous and active-high.
REQ-005 CLK  input  1  clock; all state changes on posedge.
REQ-006 RST  input  1  asynchronous, active-high reset.
REQ-007 wr_en  input  1  message-memory write strobe.
REQ-008 wr_addr  input  AW  write address.
REQ-009 wr_data  input  CHAR_W  character to store.
REQ-010 len  input  AW+1  message length, sampled on accepted start.
REQ-011 loop  input  1  1 = wrap continuously, 0 = one-shot; sampled on accepted start.
REQ-012 start  input  1  begin playback pulse.
REQ-013 stop  input  1  abort playback.
REQ-014 char_ready  input  1  consumer accepts char_out.
REQ-015 char_out  output  CHAR_W  current character.
REQ-016 char_valid  output  1  char_out is valid.
REQ-017 ptr  output  DEPTH  one-hot position of current character (bit 0 = first).
REQ-018 busy  output  1  high in RUN state.
REQ-019 done  output  1  one-cycle pulse on one-shot completion or stop.

Function
REQ-020 Internal DEPTH x CHAR_W register-file memory; write when wr_en=1, state IDLE, wr_addr < DEPTH; otherwise write ignored.
REQ-021 States IDLE, RUN; IDLE -> RUN on start=1 with effective length L >= 1; RUN -> IDLE on last character accepted in one-shot, or on stop.
REQ-022 Effective length L = min(len, DEPTH); start with len=0 ignored, stays IDLE, no done.
REQ-023 On accepted start: ptr = 1 (bit 0), char_valid=1 next cycle, char_out = mem[0]; latency start -> first valid = 1 cycle.
REQ-024 Transfer occurs on cycle where char_valid=1 and char_ready=1; ptr rotates one bit left on transfer only.
REQ-025 char_out SHALL hold stable while char_valid=1 and char_ready=0.
REQ-026 Wrap: transfer at position L-1 with loop=1 -> ptr returns to bit 0, no gap cycle, char_valid stays 1.
REQ-027 One-shot: transfer at position L-1 with loop=0 -> IDLE, char_valid=0, done=1 next cycle.
REQ-028 L=1, loop=1: same character re-presented every transfer, ptr stays bit 0.
REQ-029 start during RUN ignored; wr_en during RUN ignored.
REQ-030 stop in RUN: IDLE next cycle, char_valid=0, ptr=0, done=1 for one cycle; stop wins over a simultaneous transfer; stop in IDLE ignored.
REQ-031 start and stop asserted together in IDLE: start taken.
REQ-032 In IDLE: char_valid=0, busy=0, ptr=0, char_out=0.
REQ-033 ptr SHALL be exactly one-hot in RUN and all-zero in IDLE.

Reset
REQ-034 RST=1 immediately forces IDLE, ptr=0, char_out=0, char_valid=0, busy=0, done=0, independent of CLK.
REQ-035 Memory contents not cleared by RST.
REQ-036 RST mid-RUN aborts with no done pulse; first start after RST release plays from position 0.

Verification
REQ-037 Load "PeklarAndrewPeckEric" (20 chars), len=20, loop=1, char_ready=1 -> 20 ASCII chars 0x50,0x65,...,0x63 on consecutive cycles, then 0x50 again, ptr walks bit 0..19 and wraps.
REQ-038 Load "Peck", len=4, loop=0, char_ready=1 -> 0x50,0x65,0x63,0x6B, then char_valid=0 and one done pulse; busy low afterwards.
REQ-039 len=4, char_ready toggled 1,0,0,1,... -> char_out/ptr frozen during ready=0, no characters dropped or repeated.
REQ-040 len=0 start -> no valid, busy stays 0; len=25 with DEPTH=20 -> plays 20 chars.
REQ-041 stop at third character with char_ready=1 -> that transfer discarded, done pulse, ptr=0; wr_en during RUN leaves memory unchanged.
REQ-042 RST asserted between clock edges mid-RUN -> outputs zero before next CLK edge; memory retained; restart plays from 0x50.

Source files
------------

// File: rtl/msg_sequencer.sv
// msg_sequencer: plays a stored character message out over a valid/ready
// handshake. Characters come from an internal register-file memory that is
// loaded only while idle. Playback is one-shot or wraps continuously.
//
// Ports:
//   CLK, RST          clock; asynchronous active-high reset
//   wr_en/wr_addr/wr_data  message memory write port (ignored unless IDLE)
//   len, loop         message length and wrap mode, captured on accepted start
//   start, stop       begin / abort playback
//   char_ready        consumer accepts char_out this cycle
//   char_out          current character (0 when idle)
//   char_valid        char_out is valid
//   ptr               one-hot position of the current character (0 when idle)
//   busy              playback in progress
//   done              one-cycle pulse after one-shot completion or stop
module msg_sequencer #(
  parameter int DEPTH  = 20,
  parameter int CHAR_W = 7,
  parameter int AW     = 5
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [CHAR_W-1:0] wr_data,
  input  logic [AW:0]       len,
  input  logic              loop,
  input  logic              start,
  input  logic              stop,
  input  logic              char_ready,
  output logic [CHAR_W-1:0] char_out,
  output logic              char_valid,
  output logic [DEPTH-1:0]  ptr,
  output logic              busy,
  output logic              done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

  state_t               state_q, state_d;
  logic [AW-1:0]        pos_q, pos_d;     // binary index mirroring ptr
  logic [DEPTH-1:0]     ptr_q, ptr_d;
  logic [AW:0]          len_q, len_d;     // effective length, 1..DEPTH
  logic                 loop_q, loop_d;
  logic                 done_q, done_d;
  logic [CHAR_W-1:0]    mem_q [DEPTH];

  // Memory is not reset so a message survives RST.
  always_ff @(posedge CLK) begin
    if (wr_en && state_q == IDLE && ({1'b0, wr_addr} < DEPTH_L))
      mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      pos_q   <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      loop_q  <= loop_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    ptr_d   = ptr_q;
    len_d   = len_q;
    loop_d  = loop_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        // start beats a simultaneous stop; stop alone in IDLE does nothing
        if (start && len != '0) begin
          state_d = RUN;
          pos_d   = '0;
          ptr_d   = {{(DEPTH-1){1'b0}}, 1'b1};
          len_d   = (len > DEPTH_L) ? DEPTH_L : len;
          loop_d  = loop;
        end
      end
      RUN: begin
        // stop discards any transfer happening in the same cycle
        if (stop) begin
          state_d = IDLE;
          pos_d   = '0;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else if (char_ready) begin
          if ({1'b0, pos_q} == len_q - 1'b1) begin
            pos_d = '0;
            if (loop_q) begin
              ptr_d = {{(DEPTH-1){1'b0}}, 1'b1};
            end else begin
              state_d = IDLE;
              ptr_d   = '0;
              done_d  = 1'b1;
            end
          end else begin
            pos_d = pos_q + 1'b1;
            ptr_d = {ptr_q[DEPTH-2:0], ptr_q[DEPTH-1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so RST clears them without a clock.
  // Memory cannot change during RUN, so char_out holds while stalled.
  assign busy       = (state_q == RUN);
  assign char_valid = (state_q == RUN);
  assign char_out   = (state_q == RUN) ? mem_q[pos_q] : '0;
  assign ptr        = ptr_q;
  assign done       = done_q;

endmodule
